// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU among NUM_CORES requesters.
// Optional ALU_OPCHECK_EN: op codes > 5 are granted but not forwarded, and they complete with err=1 and result=0.
module alu_share_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int DATA_W    = 16,
   parameter int OP_W      = 3
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_CORES-1:0]      i_req,
   input  logic [NUM_CORES*DATA_W-1:0] i_bus_in,
   input  logic [NUM_CORES*DATA_W-1:0] i_ac_in,
   input  logic [NUM_CORES*OP_W-1:0] i_op_in,
   output logic [NUM_CORES-1:0]      o_gnt,
   output logic [NUM_CORES-1:0]      o_done,
   output logic [DATA_W-1:0]         o_result,
   output logic                      o_err,
   output logic                      o_busy,
   output logic [DATA_W-1:0]         o_alu_bus,
   output logic [DATA_W-1:0]         o_alu_ac,
   output logic [OP_W-1:0]           o_alu_op,
   input  logic [DATA_W-1:0]         i_alu_data
);

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic {S_IDLE, S_EXEC} state_t;
   state_t r_state, w_state_next;

   logic [DATA_W-1:0]    w_bus [NUM_CORES];
   logic [DATA_W-1:0]    w_ac  [NUM_CORES];
   logic [OP_W-1:0]      w_op  [NUM_CORES];
   logic [NUM_CORES-1:0] w_elig;
   logic                 w_found;
   logic [IDX_W-1:0]     w_win, w_cand, w_rr_next;
   logic [IDX_W:0]       w_sum;
   logic                 w_bad;

   logic [NUM_CORES-1:0] r_gnt, r_done;
   logic [DATA_W-1:0]    r_result, r_alu_bus, r_alu_ac;
   logic [OP_W-1:0]      r_alu_op;
   logic [IDX_W-1:0]     r_rr, r_owner;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
         assign w_bus[gi] = i_bus_in[gi*DATA_W +: DATA_W];
         assign w_ac[gi]  = i_ac_in[gi*DATA_W +: DATA_W];
         assign w_op[gi]  = i_op_in[gi*OP_W +: OP_W];
      end
   endgenerate

   // A core is masked in the cycle its grant is visible, so it cannot win twice on one request.
   assign w_elig = i_req & ~r_gnt;

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      w_cand  = '0;
      for (int off = 0; off < NUM_CORES; off++) begin
         w_sum = {1'b0, r_rr} + (IDX_W+1)'(off);
         if (w_sum >= (IDX_W+1)'(NUM_CORES))
            w_sum = w_sum - (IDX_W+1)'(NUM_CORES);
         w_cand = w_sum[IDX_W-1:0];
         if (!w_found && w_elig[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
      w_rr_next = (w_win == IDX_W'(NUM_CORES-1)) ? '0 : w_win + IDX_W'(1);
   end

`ifdef ALU_OPCHECK_EN
   logic r_bad, r_err;
   assign w_bad = (w_op[w_win] > OP_W'(5));
   assign o_err = r_err;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_bad <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_err <= (r_state == S_EXEC) && r_bad;
         if (w_found)
            r_bad <= w_bad;
      end
   end
`else
   assign w_bad = 1'b0;
   assign o_err = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_found)  w_state_next = S_EXEC;
         S_EXEC: if (!w_found) w_state_next = S_IDLE;
         default:              w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_gnt     <= '0;
         r_done    <= '0;
         r_result  <= '0;
         r_alu_bus <= '0;
         r_alu_ac  <= '0;
         r_alu_op  <= '0;
         r_rr      <= '0;
         r_owner   <= '0;
      end else begin
         r_gnt  <= '0;
         r_done <= '0;
         if (r_state == S_EXEC) begin
            r_done[r_owner] <= 1'b1;
`ifdef ALU_OPCHECK_EN
            r_result <= r_bad ? '0 : i_alu_data;
`else
            r_result <= i_alu_data;
`endif
         end
         // Arbitration runs on every edge so a new op can launch while the previous one completes.
         if (w_found) begin
            r_gnt[w_win] <= 1'b1;
            r_owner      <= w_win;
            r_rr         <= w_rr_next;
            if (!w_bad) begin
               r_alu_bus <= w_bus[w_win];
               r_alu_ac  <= w_ac[w_win];
               r_alu_op  <= w_op[w_win];
            end
         end
      end
   end

   assign o_gnt     = r_gnt;
   assign o_done    = r_done;
   assign o_result  = r_result;
   assign o_busy    = (r_state == S_EXEC);
   assign o_alu_bus = r_alu_bus;
   assign o_alu_ac  = r_alu_ac;
   assign o_alu_op  = r_alu_op;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small reference ALU on the shared port.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [63:0] bus_in, ac_in;
   logic [11:0] op_in;
   logic [3:0]  gnt, done;
   logic [15:0] result, alu_bus, alu_ac, alu_data;
   logic [2:0]  alu_op;
   logic        err, busy;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.NUM_CORES(4), .DATA_W(16), .OP_W(3)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_bus_in(bus_in), .i_ac_in(ac_in),
      .i_op_in(op_in), .o_gnt(gnt), .o_done(done), .o_result(result), .o_err(err),
      .o_busy(busy), .o_alu_bus(alu_bus), .o_alu_ac(alu_ac), .o_alu_op(alu_op),
      .i_alu_data(alu_data)
   );

   always_comb begin
      case (alu_op)
         3'd0:    alu_data = alu_bus + alu_ac;
         3'd1:    alu_data = alu_bus - alu_ac;
         3'd2:    alu_data = alu_bus & alu_ac;
         3'd3:    alu_data = alu_bus | alu_ac;
         3'd4:    alu_data = alu_bus ^ alu_ac;
         3'd5:    alu_data = alu_bus;
         default: alu_data = 16'hDEAD;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_core(input int i, input logic [15:0] b, input logic [15:0] a, input logic [2:0] o);
      bus_in[i*16 +: 16] = b;
      ac_in[i*16 +: 16]  = a;
      op_in[i*3 +: 3]    = o;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
   endtask

   initial begin
      rst = 1'b1; req = '0; bus_in = '0; ac_in = '0; op_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_result", 32'(result), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_alu", {alu_bus, alu_ac[12:0], alu_op}, 32'h0);
      rst = 1'b0;

      // Single op from core 1: 2 + 5
      set_core(1, 16'd2, 16'd5, 3'd0);
      req = 4'b0010;
      tick();
      chk("single_gnt", 32'(gnt), 32'h2);
      chk("single_alu_bus", 32'(alu_bus), 32'd2);
      chk("single_alu_ac", 32'(alu_ac), 32'd5);
      chk("single_alu_op", 32'(alu_op), 32'd0);
      chk("single_busy", 32'(busy), 32'h1);
      chk("single_done_early", 32'(done), 32'h0);
      req = 4'b0000;
      tick();
      chk("single_done", 32'(done), 32'h2);
      chk("single_result", 32'(result), 32'd7);
      chk("single_gnt_off", 32'(gnt), 32'h0);
      chk("single_busy_off", 32'(busy), 32'h0);
      tick();
      chk("single_done_clr", 32'(done), 32'h0);
      chk("single_result_hold", 32'(result), 32'd7);

      // Back-to-back: core2 sub, then core3 and
      set_core(2, 16'd10, 16'd3, 3'd1);
      req = 4'b0100;
      tick();
      chk("b2b_gnt2", 32'(gnt), 32'h4);
      set_core(3, 16'h00F0, 16'h0FF0, 3'd2);
      req = 4'b1000;
      tick();
      chk("b2b_gnt3", 32'(gnt), 32'h8);
      chk("b2b_done2", 32'(done), 32'h4);
      chk("b2b_result2", 32'(result), 32'd7);
      chk("b2b_busy", 32'(busy), 32'h1);
      chk("b2b_alu_op", 32'(alu_op), 32'd2);
      req = 4'b0000;
      tick();
      chk("b2b_done3", 32'(done), 32'h8);
      chk("b2b_result3", 32'(result), 32'h00F0);
      chk("b2b_busy_off", 32'(busy), 32'h0);

      // Full contention, rotation pointer at 0
      set_core(0, 16'd1, 16'd1, 3'd0);
      set_core(1, 16'h8000, 16'h8000, 3'd0);
      set_core(2, 16'd5, 16'd3, 3'd3);
      set_core(3, 16'hAAAA, 16'hFFFF, 3'd4);
      req = 4'b1111;
      tick();
      chk("rr_gnt0", 32'(gnt), 32'h1);
      tick();
      chk("rr_gnt1", 32'(gnt), 32'h2);
      chk("rr_done0", 32'(done), 32'h1);
      chk("rr_res0", 32'(result), 32'd2);
      tick();
      chk("rr_gnt2", 32'(gnt), 32'h4);
      chk("rr_done1", 32'(done), 32'h2);
      chk("rr_res1", 32'(result), 32'd0);
      tick();
      chk("rr_gnt3", 32'(gnt), 32'h8);
      chk("rr_done2", 32'(done), 32'h4);
      chk("rr_res2", 32'(result), 32'd7);
      tick();
      chk("rr_gnt0_again", 32'(gnt), 32'h1);
      chk("rr_done3", 32'(done), 32'h8);
      chk("rr_res3", 32'(result), 32'h5555);
      req = 4'b0000;
      tick();
      chk("rr_done0_again", 32'(done), 32'h1);
      chk("rr_res0_again", 32'(result), 32'd2);

      // Single continuous requester alternates
      req = 4'b0001;
      tick();
      chk("cont_gnt_a", 32'(gnt), 32'h1);
      tick();
      chk("cont_gnt_b", 32'(gnt), 32'h0);
      chk("cont_done_b", 32'(done), 32'h1);
      chk("cont_busy_b", 32'(busy), 32'h0);
      tick();
      chk("cont_gnt_c", 32'(gnt), 32'h1);
      tick();
      chk("cont_gnt_d", 32'(gnt), 32'h0);
      req = 4'b0000;
      tick();

      // Unimplemented op 7 from core 2; ALU inputs currently hold core0's 1,1,add
      set_core(2, 16'h1234, 16'h0001, 3'd7);
      req = 4'b0100;
      tick();
      chk("bad_gnt", 32'(gnt), 32'h4);
`ifdef ALU_OPCHECK_EN
      chk("bad_alu_bus_held", 32'(alu_bus), 32'd1);
      chk("bad_alu_op_held", 32'(alu_op), 32'd0);
`else
      chk("bad_alu_bus_fwd", 32'(alu_bus), 32'h1234);
      chk("bad_alu_op_fwd", 32'(alu_op), 32'd7);
`endif
      req = 4'b0000;
      tick();
      chk("bad_done", 32'(done), 32'h4);
`ifdef ALU_OPCHECK_EN
      chk("bad_err", 32'(err), 32'h1);
      chk("bad_result", 32'(result), 32'h0);
`else
      chk("bad_err", 32'(err), 32'h0);
      chk("bad_result", 32'(result), 32'hDEAD);
`endif
      tick();
      chk("bad_err_clr", 32'(err), 32'h0);

      // Reset in the middle of an op from core 0 (pointer currently at 3)
      set_core(2, 16'd5, 16'd3, 3'd3);
      req = 4'b0001;
      tick();
      chk("mid_gnt0", 32'(gnt), 32'h1);
      chk("mid_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_gnt", 32'(gnt), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_alu_bus", 32'(alu_bus), 32'h0);
      chk("mid_rst_result", 32'(result), 32'h0);
      req = 4'b1111;
      tick();
      chk("mid_rst_no_done", 32'(done), 32'h0);
      rst = 1'b0;
      tick();
      chk("post_rst_gnt0", 32'(gnt), 32'h1);
      chk("post_rst_done", 32'(done), 32'h0);
      req = 4'b0000;
      tick();
      chk("post_rst_done0", 32'(done), 32'h1);
      chk("post_rst_res0", 32'(result), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
